// File: rtl/secuenciador_banco.sv
// Register-bank sequencer: one register-to-register ALU op per handshake,
// IDLE -> READ -> EXEC -> WRITE. Optional macro SECUENCIADOR_ZERO_REG_EN suppresses writes to r0.
module secuenciador_banco (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [2:0]  func,
  output logic [4:0]  ar_1,
  output logic [4:0]  ar_2,
  input  logic [31:0] dr_1,
  input  logic [31:0] dr_2,
  output logic [4:0]  aw,
  output logic [31:0] data_out,
  output logic        writereg,
  output logic        done,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [4:0]         ar1_q, ar1_d, ar2_q, ar2_d;
  logic [4:0]         rd_q, rd_d, aw_q, aw_d;
  logic [2:0]         func_q, func_d;
  logic signed [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [31:0]        res_q, res_d;

  function automatic logic [31:0] alu(input logic [2:0] f,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    case (f)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      3'b101:  alu = {31'd0, (a < b)};
      3'b110:  alu = ~(a | b);
      default: alu = a;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    ar1_d   = ar1_q;
    ar2_d   = ar2_q;
    rd_d    = rd_q;
    func_d  = func_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    aw_d    = aw_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ar1_d   = rs;
          ar2_d   = rt;
          rd_d    = rd;
          func_d  = func;
          state_d = READ;
        end
      end
      // Addresses have been stable a full cycle, so the bank data is valid here.
      READ: begin
        opa_d   = dr_1;
        opb_d   = dr_2;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu(func_q, opa_q, opb_q);
        aw_d    = rd_q;
        state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ar1_q   <= '0;
      ar2_q   <= '0;
      rd_q    <= '0;
      func_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      aw_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ar1_q   <= ar1_d;
      ar2_q   <= ar2_d;
      rd_q    <= rd_d;
      func_q  <= func_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      aw_q    <= aw_d;
      res_q   <= res_d;
    end
  end

  // Strobes decode the state directly so an async reset drops them at once.
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == WRITE);
`ifdef SECUENCIADOR_ZERO_REG_EN
  assign writereg = (state_q == WRITE) && (aw_q != 5'd0);
`else
  assign writereg = (state_q == WRITE);
`endif
  assign ar_1     = ar1_q;
  assign ar_2     = ar2_q;
  assign aw       = aw_q;
  assign data_out = res_q;

endmodule

// File: doc/secuenciador_banco.md
# secuenciador_banco

Initiator-side sequencer for the 32×32 register bank (two combinational read ports and one write port with write enable). It accepts one register-to-register operation per handshake, drives the bank's read addresses, captures both operands, computes a 32-bit ALU result and issues exactly one write-back cycle. It sits between the instruction decode logic and the register bank and is the only block that drives the bank's write port.

## Interface
- No parameters; address width is 5 bits and data width is 32 bits.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  sequencer can accept a request; high only in IDLE.
- rs  input  5  source register A address.
- rt  input  5  source register B address.
- rd  input  5  destination register address.
- func  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 NOR, 111 pass A.
- ar_1  output  5  bank read address 1.
- ar_2  output  5  bank read address 2.
- dr_1  input  32  bank read data 1, combinational from ar_1.
- dr_2  input  32  bank read data 2, combinational from ar_2.
- aw  output  5  bank write address.
- data_out  output  32  bank write data.
- writereg  output  1  bank write enable; one-cycle pulse.
- done  output  1  one-cycle pulse, coincident with writereg.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE → READ → EXEC → WRITE → IDLE. There are no other transitions and no stalls.
- IDLE: in_ready=1. On in_valid&in_ready at a clock edge, latch rs/rt/rd/func, drive ar_1=rs and ar_2=rt from registers, and go to READ. Inputs are ignored outside this handshake.
- READ: sample dr_1/dr_2 into operand registers A/B at the clock edge, then go to EXEC.
- EXEC: compute result = f(A,B) per func and register it, drive aw=rd and data_out=result, then go to WRITE.
- WRITE: writereg=1 and done=1 for exactly this cycle, then go to IDLE.
- Arithmetic: ADD/SUB are modulo 2^32 with carry and overflow discarded. SLT yields 32'd1 if $signed(A)<$signed(B), else 32'd0.
- rs==rt is legal; both ports read the same register.
- rd equal to rs or rt is legal. Operands are captured before the write, so read-before-write is guaranteed.
- ar_1/ar_2/aw/data_out hold their last values in IDLE. writereg is low whenever the state is not WRITE.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, in_ready=1, busy=0, writereg=0, done=0, ar_1=ar_2=aw=0, data_out=0, operands=0.
- Accept at edge E0, operand capture at E1, result registered at E2, writereg/done high from E2 to E3, in_ready high again after E3.
- Latency from accept to write is 3 cycles. Throughput is one operation per 4 cycles.
- A new request can be accepted at E3+1 at the earliest. A request held with in_valid during busy is accepted only on the first IDLE edge.
- Reset asserted mid-operation aborts immediately: writereg drops asynchronously and no partial write is issued.
- The bank must present dr_1/dr_2 within one cycle of the ar change. The address outputs are registered, so there is a full cycle of setup.

## Configuration
- SECUENCIADOR_ZERO_REG_EN defined: any operation with rd==0 still runs the full FSM and pulses done, but writereg stays 0 in WRITE, so register 0 is never written.
- SECUENCIADOR_ZERO_REG_EN undefined: rd==0 is written like any other register.

## Test plan
- Reset mid-EXEC with rs=1, rt=2, rd=3 → writereg never pulses, all outputs at reset values, in_ready=1 the cycle after rst deasserts.
- Bank R1=5, R2=7; ADD rs=1, rt=2, rd=3 accepted at E0 → at E2 aw=3, data_out=12, writereg=done=1 for one cycle; in_ready=1 after E3.
- Bank R4=0xFFFFFFFF, R5=1; SUB rs=5, rt=4, rd=6 → data_out=0x00000002. Repeat with SLT → data_out=0 (1 < -1 is false).
- Back-to-back: in_valid held high with two queued ops → second accepted exactly 4 cycles after the first; no extra writereg pulses.
- Bank R8=0x0F0F0F0F; XOR rs=8, rt=8, rd=8 → data_out=0, aw=8. The next read of R8 returns 0.
- rd=0, ADD of R1=5 and R2=7 → with SECUENCIADOR_ZERO_REG_EN, done=1 and writereg=0. Without it, writereg=1 and data_out=12.
